io_timer: RTL and testbench
===========================

Name: io_timer

Overview:
- Memory-mapped timer peripheral at FF04–FF07: DIV, TIMA, TMA, TAC.
- Acts as the responder on the CPU/MMU data bus and is driven by DZCPU `smw`/`srm` accesses.
- Implements the 16-bit system counter, the falling-edge TIMA clocking, TMA reload and the timer interrupt request.
- Instanced beside MMU; MMU routes iAddr/iData/iWe to it and muxes oData when oHit=1.

Parameters:
- BASE_ADDR, 16'hFF04, address of DIV; TIMA/TMA/TAC at +1/+2/+3.
- CLK_PER_TICK, 1, number of iClock cycles per internal counter increment (1..256); counter advances on the prescaler strobe only.

Ports:
- iClock  in  1  system clock.
- iReset  in  1  asynchronous, active-low reset.
- iAddr  in  16  bus address.
- iData  in  8  write data.
- iWe  in  1  write strobe; one write per cycle it is high.
- oData  out  8  read data, registered.
- oHit  out  1  combinational; iAddr within BASE_ADDR..BASE_ADDR+3.
- iIrqAck  in  1  clears the pending timer interrupt.
- oTimerIrq  out  1  sticky timer interrupt request.

Behaviour:
- Reset (iReset=0, async):
  - rCounter=16'h0000, TIMA=00, TMA=00, TAC=3'b000.
  - oData=8'h00, oTimerIrq=0, prescaler=0, overflow state IDLE.
- Prescaler: wraps at CLK_PER_TICK-1; tick strobe asserted on wrap. With CLK_PER_TICK=1, tick is asserted every cycle.
- Counter: on tick, rCounter <= rCounter+1 (16-bit wrap). DIV read = rCounter[15:8].
- Register writes (iWe && oHit), all take effect next cycle:
  - Write to DIV, any data: rCounter <= 0 and prescaler <= 0.
  - Write to TIMA: TIMA <= iData.
  - Write to TMA: TMA <= iData.
  - Write to TAC: TAC <= iData[2:0].
- Selected bit: TAC[1:0] selects rCounter bit 00->9, 01->3, 10->5, 11->7.
- TIMA clock: sel = TAC[2] & rCounter[bit]. A registered copy of sel is kept; a 1->0 transition of sel increments TIMA.
  - Glitches are included: a DIV write or TAC change that drops sel also increments TIMA, as on hardware.
- Overflow (feature off): increment from FF gives TIMA <= TMA in the same cycle and sets oTimerIrq.
- Simultaneous events:
  - CPU write to TIMA in the same cycle as an increment: write wins, no overflow.
  - TMA write in the reload cycle: the new iData is the reload value.
  - Set and iIrqAck in the same cycle: set wins, oTimerIrq stays 1.
  - iIrqAck alone clears oTimerIrq next cycle.
- Reads: oData <= register at iAddr one cycle after the address is presented (1-cycle latency, matching the `sma`->`srm` pair).
  - DIV -> rCounter[15:8]; TIMA -> TIMA; TMA -> TMA; TAC -> {5'b11111, TAC}.
  - Not hit -> 8'hFF.
- Reads have no side effects; oData updates every cycle regardless of iWe.
- Reset asserted mid-overflow: all state returns to reset values immediately; any pending reload/IRQ is discarded.

Optional Feature:
- Macro: TIMER_OVERFLOW_DELAY_EN.
- Defined — hardware-accurate delayed reload:
  - Overflow sets TIMA=00 and enters state DELAY for 4 ticks.
  - On the 4th tick, TIMA <= TMA, oTimerIrq set, return to IDLE.
  - A TIMA write during DELAY cancels the reload and IRQ; the written value stands.
  - A TMA write during DELAY changes the value reloaded.
- Undefined: immediate reload as in Behaviour; the DELAY state is not built.

Test Plan:
- Reset: hold iReset=0, then release; read FF04..FF07 -> 00,00,00,F8; oTimerIrq=0; oHit=0 and oData=FF for iAddr=C000.
- DIV: after release, wait 512 cycles (CLK_PER_TICK=1) and read FF04 -> 02. Write FF04=5A, next read -> 00.
- TIMA rate: write TAC=05 and TIMA=00, wait 160 cycles, read FF05 -> 0A (±1 for phase). With TAC=01 (disabled), TIMA stays constant.
- Overflow:
  - TMA=AB, TIMA=FE, TAC=05; after 32 cycles TIMA=AB and oTimerIrq=1.
  - Pulse iIrqAck -> oTimerIrq=0 next cycle.
  - iIrqAck coincident with a new overflow -> oTimerIrq stays 1.
- Glitch: TAC=04, counter bit9=1 (wait 512 cycles after a DIV write), then write FF04 -> TIMA increments by exactly 1.
- With TIMER_OVERFLOW_DELAY_EN:
  - TIMA=FF overflow reads 00 for 4 cycles, then AB with the IRQ.
  - A TIMA write of 33 inside the window gives TIMA=33 and no IRQ.

Source files
------------

// File: rtl/io_timer.sv
// io_timer: DIV/TIMA/TMA/TAC timer peripheral with falling-edge TIMA clocking, TMA reload and sticky IRQ.
// Optional macro TIMER_OVERFLOW_DELAY_EN builds the 4-tick delayed reload after a TIMA overflow.
module io_timer #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF04,
  parameter int          CLK_PER_TICK = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iAddr,
  input  logic [7:0]  iData,
  input  logic        iWe,
  output logic [7:0]  oData,
  output logic        oHit,
  input  logic        iIrqAck,
  output logic        oTimerIrq
);

  localparam int            PW            = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_PER_TICK - 1);

  logic [PW-1:0] prescale;
  logic          tick;
  logic [15:0]   counter;
  logic [7:0]    tima;
  logic [7:0]    tma;
  logic [2:0]    tac;
  logic [15:0]   offset;
  logic [1:0]    reg_sel;
  logic          wr_div;
  logic          wr_tima;
  logic          wr_tma;
  logic          wr_tac;
  logic          counter_bit;
  logic          sel;
  logic          sel_q;
  logic          fall;
  logic [7:0]    reload_val;
  logic [7:0]    rd_val;
  logic          irq_set;

  // Unsigned offset wraps for addresses below BASE_ADDR, so one range test covers both sides.
  assign offset  = iAddr - BASE_ADDR;
  assign oHit    = (offset[15:2] == 14'd0);
  assign reg_sel = offset[1:0];

  assign wr_div  = iWe && oHit && (reg_sel == 2'd0);
  assign wr_tima = iWe && oHit && (reg_sel == 2'd1);
  assign wr_tma  = iWe && oHit && (reg_sel == 2'd2);
  assign wr_tac  = iWe && oHit && (reg_sel == 2'd3);

  assign tick = (prescale == PRESCALE_LAST);

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      prescale <= '0;
      counter  <= '0;
    end else if (wr_div) begin
      prescale <= '0;
      counter  <= '0;
    end else if (tick) begin
      prescale <= '0;
      counter  <= counter + 16'd1;
    end else begin
      prescale <= prescale + PW'(1);
    end
  end

  always_comb begin
    counter_bit = 1'b0;
    case (tac[1:0])
      2'b00:   counter_bit = counter[9];
      2'b01:   counter_bit = counter[3];
      2'b10:   counter_bit = counter[5];
      default: counter_bit = counter[7];
    endcase
  end

  // Any drop of sel clocks TIMA, including drops caused by DIV resets or TAC writes.
  assign sel  = tac[2] & counter_bit;
  assign fall = sel_q & ~sel;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      sel_q <= 1'b0;
    end else begin
      sel_q <= sel;
    end
  end

  assign reload_val = wr_tma ? iData : tma;

`ifdef TIMER_OVERFLOW_DELAY_EN
  // state | meaning
  // IDLE  | TIMA counting normally
  // DELAY | TIMA overflowed and reads 00; TMA reload and IRQ on the 4th tick
  typedef enum logic {IDLE, DELAY} state_t;

  state_t     state;
  logic [1:0] dly_cnt;
  logic       reload_now;

  assign reload_now = (state == DELAY) && tick && (dly_cnt == 2'd3);
  assign irq_set    = reload_now && !wr_tima;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state   <= IDLE;
      dly_cnt <= 2'd0;
      tima    <= 8'h00;
    end else begin
      if (wr_tima) begin
        tima  <= iData;
        state <= IDLE;
      end else if (reload_now) begin
        tima  <= reload_val;
        state <= IDLE;
      end else if (fall) begin
        if (tima == 8'hFF) begin
          tima    <= 8'h00;
          state   <= DELAY;
          dly_cnt <= 2'd0;
        end else begin
          tima <= tima + 8'd1;
        end
      end
      if ((state == DELAY) && tick && !reload_now) begin
        dly_cnt <= dly_cnt + 2'd1;
      end
    end
  end
`else
  assign irq_set = fall && (tima == 8'hFF) && !wr_tima;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      tima <= 8'h00;
    end else if (wr_tima) begin
      tima <= iData;
    end else if (fall) begin
      tima <= (tima == 8'hFF) ? reload_val : tima + 8'd1;
    end
  end
`endif

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      tma <= 8'h00;
      tac <= 3'b000;
    end else begin
      if (wr_tma) tma <= iData;
      if (wr_tac) tac <= iData[2:0];
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      oTimerIrq <= 1'b0;
    end else if (irq_set) begin
      oTimerIrq <= 1'b1;
    end else if (iIrqAck) begin
      oTimerIrq <= 1'b0;
    end
  end

  always_comb begin
    rd_val = 8'hFF;
    if (oHit) begin
      case (reg_sel)
        2'd0:    rd_val = counter[15:8];
        2'd1:    rd_val = tima;
        2'd2:    rd_val = tma;
        default: rd_val = {5'b11111, tac};
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      oData <= 8'h00;
    end else begin
      oData <= rd_val;
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed bench for io_timer with CLK_PER_TICK=1; tasks sit on the falling edge between bus cycles.
`timescale 1ns/1ps
module tb_io_timer;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iAddr;
  logic [7:0]  iData;
  logic        iWe;
  logic [7:0]  oData;
  logic        oHit;
  logic        iIrqAck;
  logic        oTimerIrq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [15:0] A_DIV  = 16'hFF04;
  localparam logic [15:0] A_TIMA = 16'hFF05;
  localparam logic [15:0] A_TMA  = 16'hFF06;
  localparam logic [15:0] A_TAC  = 16'hFF07;
`ifdef TIMER_OVERFLOW_DELAY_EN
  localparam int DLY = 4;
`else
  localparam int DLY = 0;
`endif

  io_timer #(.BASE_ADDR(16'hFF04), .CLK_PER_TICK(1)) dut (
    .iClock   (iClock),
    .iReset   (iReset),
    .iAddr    (iAddr),
    .iData    (iData),
    .iWe      (iWe),
    .oData    (oData),
    .oHit     (oHit),
    .iIrqAck  (iIrqAck),
    .oTimerIrq(oTimerIrq)
  );

  always #5 iClock = ~iClock;

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    iAddr = a;
    iData = d;
    iWe   = 1'b1;
    @(negedge iClock);
    iWe   = 1'b0;
    iAddr = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] v);
    iAddr = a;
    @(negedge iClock);
    v     = oData;
    iAddr = 16'h0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic ack_pulse();
    iIrqAck = 1'b1;
    @(negedge iClock);
    iIrqAck = 1'b0;
  endtask

  // TIMA <= tv with TAC=05 and the counter realigned; the first TIMA clock lands on the 15th posedge after return.
  task automatic arm(input logic [7:0] tv);
    wr(A_TAC, 8'h00);
    wr(A_DIV, 8'h00);
    wr(A_TIMA, tv);
    wr(A_TAC, 8'h05);
  endtask

  task automatic test_reset();
    logic [7:0]  v;
    logic [15:0] hit_addr [4];
    logic        hit_exp  [4];
    hit_addr = '{16'hFF03, 16'hFF04, 16'hFF07, 16'hFF08};
    hit_exp  = '{1'b0, 1'b1, 1'b1, 1'b0};
    iReset = 1'b0; iAddr = 16'h0000; iData = 8'h00; iWe = 1'b0; iIrqAck = 1'b0;
    repeat (3) @(negedge iClock);
    total_cnt++; if (oData !== 8'h00) $display("FAIL reset_odata: got %h want 00", oData); else pass_cnt++;
    total_cnt++; if (oTimerIrq !== 1'b0) $display("FAIL reset_irq: got %b want 0", oTimerIrq); else pass_cnt++;
    iReset = 1'b1;
    rd(A_DIV, v);
    total_cnt++; if (v !== 8'h00) $display("FAIL reset_div: got %h want 00", v); else pass_cnt++;
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'h00) $display("FAIL reset_tima: got %h want 00", v); else pass_cnt++;
    rd(A_TMA, v);
    total_cnt++; if (v !== 8'h00) $display("FAIL reset_tma: got %h want 00", v); else pass_cnt++;
    rd(A_TAC, v);
    total_cnt++; if (v !== 8'hF8) $display("FAIL reset_tac: got %h want F8", v); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      iAddr = hit_addr[i];
      #1;
      total_cnt++;
      if (oHit !== hit_exp[i]) $display("FAIL hit_%h: got %b want %b", hit_addr[i], oHit, hit_exp[i]);
      else pass_cnt++;
    end
    iAddr = 16'hC000;
    #0.5;
    total_cnt++; if (oHit !== 1'b0) $display("FAIL hit_c000: got %b want 0", oHit); else pass_cnt++;
    @(negedge iClock);
    total_cnt++; if (oData !== 8'hFF) $display("FAIL miss_read: got %h want FF", oData); else pass_cnt++;
    iAddr = 16'h0000;
  endtask

  task automatic test_div();
    logic [7:0] v;
    wr(A_DIV, 8'h00);
    idle(255);
    rd(A_DIV, v);
    total_cnt++; if (v !== 8'h00) $display("FAIL div_255: got %h want 00", v); else pass_cnt++;
    rd(A_DIV, v);
    total_cnt++; if (v !== 8'h01) $display("FAIL div_256: got %h want 01", v); else pass_cnt++;
    idle(264);
    rd(A_DIV, v);
    total_cnt++; if (v !== 8'h02) $display("FAIL div_521: got %h want 02", v); else pass_cnt++;
    wr(A_DIV, 8'h5A);
    rd(A_DIV, v);
    total_cnt++; if (v !== 8'h00) $display("FAIL div_clear: got %h want 00", v); else pass_cnt++;
  endtask

  task automatic test_tima_rate();
    logic [7:0] v;
    wr(A_DIV, 8'h00);
    wr(A_TAC, 8'h05);
    wr(A_TIMA, 8'h00);
    idle(160);
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'h0A) $display("FAIL rate_tac05: got %h want 0A", v); else pass_cnt++;
    wr(A_TAC, 8'h01);
    idle(100);
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'h0A) $display("FAIL rate_disabled: got %h want 0A", v); else pass_cnt++;
    wr(A_DIV, 8'h00);
    wr(A_TIMA, 8'h00);
    wr(A_TAC, 8'h06);
    idle(200);
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'h03) $display("FAIL rate_tac06: got %h want 03", v); else pass_cnt++;
    rd(A_TAC, v);
    total_cnt++; if (v !== 8'hFE) $display("FAIL tac_readback: got %h want FE", v); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    logic [7:0] exp;
    wr(A_TMA, 8'hAB);
    arm(8'hFE);
    idle(15);
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'hFF) $display("FAIL ovf_pre: got %h want FF", v); else pass_cnt++;
    total_cnt++; if (oTimerIrq !== 1'b0) $display("FAIL ovf_pre_irq: got %b want 0", oTimerIrq); else pass_cnt++;
    idle(15);
    rd(A_TIMA, v);
`ifdef TIMER_OVERFLOW_DELAY_EN
    exp = 8'h00;
`else
    exp = 8'hAB;
`endif
    total_cnt++; if (v !== exp) $display("FAIL ovf_first: got %h want %h", v, exp); else pass_cnt++;
`ifdef TIMER_OVERFLOW_DELAY_EN
    total_cnt++; if (oTimerIrq !== 1'b0) $display("FAIL dly_irq_early: got %b want 0", oTimerIrq); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      rd(A_TIMA, v);
      total_cnt++; if (v !== 8'h00) $display("FAIL dly_window_%0d: got %h want 00", i, v); else pass_cnt++;
    end
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'hAB) $display("FAIL dly_reload: got %h want AB", v); else pass_cnt++;
`endif
    total_cnt++; if (oTimerIrq !== 1'b1) $display("FAIL ovf_irq: got %b want 1", oTimerIrq); else pass_cnt++;
    idle(3);
    total_cnt++; if (oTimerIrq !== 1'b1) $display("FAIL irq_sticky: got %b want 1", oTimerIrq); else pass_cnt++;
    ack_pulse();
    total_cnt++; if (oTimerIrq !== 1'b0) $display("FAIL irq_ack: got %b want 0", oTimerIrq); else pass_cnt++;
  endtask

  task automatic test_ack_collide();
    logic [7:0] v;
    arm(8'hFF);
    idle(14 + DLY);
    ack_pulse();
    total_cnt++; if (oTimerIrq !== 1'b1) $display("FAIL ack_collide_irq: got %b want 1", oTimerIrq); else pass_cnt++;
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'hAB) $display("FAIL ack_collide_tima: got %h want AB", v); else pass_cnt++;
    ack_pulse();
    total_cnt++; if (oTimerIrq !== 1'b0) $display("FAIL ack_after_collide: got %b want 0", oTimerIrq); else pass_cnt++;
  endtask

  task automatic test_write_wins();
    logic [7:0] v;
    arm(8'hFF);
    idle(14);
    wr(A_TIMA, 8'h42);
    idle(8);
    total_cnt++; if (oTimerIrq !== 1'b0) $display("FAIL write_wins_irq: got %b want 0", oTimerIrq); else pass_cnt++;
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'h42) $display("FAIL write_wins_tima: got %h want 42", v); else pass_cnt++;
  endtask

  task automatic test_tma_reload();
    logic [7:0] v;
    arm(8'hFF);
    idle(14 + DLY);
    wr(A_TMA, 8'hC3);
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'hC3) $display("FAIL tma_reload_tima: got %h want C3", v); else pass_cnt++;
    total_cnt++; if (oTimerIrq !== 1'b1) $display("FAIL tma_reload_irq: got %b want 1", oTimerIrq); else pass_cnt++;
    rd(A_TMA, v);
    total_cnt++; if (v !== 8'hC3) $display("FAIL tma_readback: got %h want C3", v); else pass_cnt++;
    ack_pulse();
  endtask

  task automatic test_delay_cancel();
`ifdef TIMER_OVERFLOW_DELAY_EN
    logic [7:0] v;
    arm(8'hFF);
    idle(15);
    wr(A_TIMA, 8'h33);
    idle(8);
    total_cnt++; if (oTimerIrq !== 1'b0) $display("FAIL dly_cancel_irq: got %b want 0", oTimerIrq); else pass_cnt++;
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'h33) $display("FAIL dly_cancel_tima: got %h want 33", v); else pass_cnt++;
`endif
  endtask

  task automatic test_glitch();
    logic [7:0] v;
    wr(A_TAC, 8'h00);
    wr(A_DIV, 8'h00);
    wr(A_TIMA, 8'h10);
    wr(A_TAC, 8'h04);
    idle(600);
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'h10) $display("FAIL glitch_pre: got %h want 10", v); else pass_cnt++;
    wr(A_DIV, 8'h77);
    idle(1);
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'h11) $display("FAIL glitch_inc: got %h want 11", v); else pass_cnt++;
    idle(100);
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'h11) $display("FAIL glitch_once: got %h want 11", v); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    arm(8'hFF);
    idle(15);
`ifndef TIMER_OVERFLOW_DELAY_EN
    total_cnt++; if (oTimerIrq !== 1'b1) $display("FAIL mid_pre_irq: got %b want 1", oTimerIrq); else pass_cnt++;
`endif
    #2 iReset = 1'b0;
    #1;
    total_cnt++; if (oTimerIrq !== 1'b0) $display("FAIL mid_async_irq: got %b want 0", oTimerIrq); else pass_cnt++;
    total_cnt++; if (oData !== 8'h00) $display("FAIL mid_async_odata: got %h want 00", oData); else pass_cnt++;
    @(negedge iClock);
    @(negedge iClock);
    iReset = 1'b1;
    rd(A_TIMA, v);
    total_cnt++; if (v !== 8'h00) $display("FAIL mid_tima: got %h want 00", v); else pass_cnt++;
    rd(A_TMA, v);
    total_cnt++; if (v !== 8'h00) $display("FAIL mid_tma: got %h want 00", v); else pass_cnt++;
    idle(10);
    total_cnt++; if (oTimerIrq !== 1'b0) $display("FAIL mid_irq_discard: got %b want 0", oTimerIrq); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_div();
    test_tima_rate();
    test_overflow();
    test_ack_collide();
    test_write_wins();
    test_tma_reload();
    test_delay_cancel();
    test_glitch();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
